// File: rtl/ppa_seq_pkg.sv
// Shared types and helpers for the multi-word prefix-adder sequencer.
package ppa_seq_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} seq_state_t;

    localparam int ADDER_W = 32;

    function automatic logic signed_ovf(
        input logic a_msb,
        input logic b_msb,
        input logic s_msb
    );
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/ladner_fischer_32bits.sv
// 32-bit parallel-prefix adder (Ladner-Fischer tree), purely combinational.
module ladner_fischer_32bits
    import ppa_seq_pkg::*;
(
    input  logic [ADDER_W-1:0] a,
    input  logic [ADDER_W-1:0] b,
    input  logic               cin,
    output logic [ADDER_W-1:0] sum,
    output logic               cout
);

    localparam int LEVELS = $clog2(ADDER_W);

    logic [ADDER_W-1:0] pg;
    logic [ADDER_W-1:0] g;
    logic [ADDER_W-1:0] p;

    assign pg = a ^ b;

    // Cin folded into bit 0 so g[i] ends up as the carry out of bit i.
    always_comb begin
        g = a & b;
        p = pg;
        g[0] = g[0] | (p[0] & cin);
        for (int l = 0; l < LEVELS; l++) begin
            for (int i = 0; i < ADDER_W; i++) begin
                if (((i >> l) & 1) == 1) begin
                    g[i] = g[i] | (p[i] & g[((i >> l) << l) - 1]);
                    p[i] = p[i] & p[((i >> l) << l) - 1];
                end
            end
        end
    end

    assign sum  = pg ^ {g[ADDER_W-2:0], cin};
    assign cout = g[ADDER_W-1];

endmodule

// File: rtl/ppa_multiword_add_seq.sv
// Multi-precision add/sub sequencer: one 32-bit word per cycle, LSW first,
// through a single shared prefix adder with carry chained between words.
module ppa_multiword_add_seq
    import ppa_seq_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int NWORDS = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WIDTH*NWORDS-1:0] in_a,
    input  logic [WIDTH*NWORDS-1:0] in_b,
    input  logic                    in_cin,
    input  logic                    in_sub,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH*NWORDS-1:0] out_sum,
    output logic                    out_cout,
    output logic                    out_ovf,
    output logic                    busy
);

    localparam int TW = WIDTH * NWORDS;
    localparam int CW = $clog2(NWORDS);
    localparam logic [CW-1:0] LAST = CW'(NWORDS - 1);

    seq_state_t state;
    seq_state_t next_state;

    logic [TW-1:0]       a_reg;
    logic [TW-1:0]       b_reg;
    logic [TW-WIDTH-1:0] acc;
    logic [TW-1:0]       acc_shift;
    logic [CW-1:0]       cnt;
    logic                carry;
    logic                a_msb;
    logic                b_msb;
    logic [WIDTH-1:0]    adder_sum;
    logic                adder_cout;
    logic                accept;
    logic                last;

    assign accept = in_valid && in_ready;
    assign last   = (cnt == LAST);
    assign busy   = (state != IDLE);

    // Operands shift right each cycle so the adder always sees word 0.
    ladner_fischer_32bits u_adder (
        .a    (a_reg[WIDTH-1:0]),
        .b    (b_reg[WIDTH-1:0]),
        .cin  (carry),
        .sum  (adder_sum),
        .cout (adder_cout)
    );

    assign acc_shift = {adder_sum, acc};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (accept) next_state = RUN;
            RUN:  if (last) next_state = DONE;
            DONE: if (out_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_cout  <= 1'b0;
            out_ovf   <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            acc       <= '0;
            cnt       <= '0;
            carry     <= 1'b0;
            a_msb     <= 1'b0;
            b_msb     <= 1'b0;
        end else begin
            in_ready  <= (next_state == IDLE);
            out_valid <= (next_state == DONE);
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_reg <= in_a;
                        b_reg <= in_sub ? ~in_b : in_b;
                        carry <= in_sub | in_cin;
                        a_msb <= in_a[TW-1];
                        b_msb <= in_sub ? ~in_b[TW-1] : in_b[TW-1];
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    a_reg <= a_reg >> WIDTH;
                    b_reg <= b_reg >> WIDTH;
                    acc   <= acc_shift[TW-1:WIDTH];
                    carry <= adder_cout;
                    cnt   <= last ? '0 : cnt + CW'(1);
                    if (last) begin
                        out_sum  <= acc_shift;
                        out_cout <= adder_cout;
                        out_ovf  <= signed_ovf(a_msb, b_msb,
                                               adder_sum[WIDTH-1]);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ppa_multiword_add_seq.sv
// Self-checking bench for ppa_multiword_add_seq against an arithmetic model.
module tb_ppa_multiword_add_seq;

    localparam int NW = 4;
    localparam int TW = 32 * NW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [TW-1:0] in_a = '0;
    logic [TW-1:0] in_b = '0;
    logic          in_cin = 1'b0;
    logic          in_sub = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [TW-1:0] out_sum;
    logic          out_cout;
    logic          out_ovf;
    logic          busy;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    ppa_multiword_add_seq #(.WIDTH(32), .NWORDS(NW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [TW-1:0] obs,
                       input logic [TW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // {ovf, cout, sum} from plain signed/unsigned arithmetic
    function automatic logic [TW+1:0] ref_op(input logic [TW-1:0] a,
                                             input logic [TW-1:0] b,
                                             input logic cin,
                                             input logic sub);
        logic signed [TW+1:0] sa;
        logic signed [TW+1:0] sb;
        logic signed [TW+1:0] r;
        logic [TW:0]          u;
        logic                 cout;
        sa = {{2{a[TW-1]}}, a};
        sb = {{2{b[TW-1]}}, b};
        if (sub) begin
            r = sa - sb;
            cout = (a >= b);
        end else begin
            r = sa + sb + (TW+2)'(cin);
            u = {1'b0, a} + {1'b0, b} + (TW+1)'(cin);
            cout = u[TW];
        end
        return {r[TW] != r[TW-1], cout, r[TW-1:0]};
    endfunction

    function automatic logic [TW-1:0] rnd_word();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic wait_ready(input string tag);
        int w = 0;
        while (in_ready !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk({tag, " rdy"}, TW'(in_ready), TW'(1));
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic [TW-1:0] a,
                          input logic [TW-1:0] b, input logic cin,
                          input logic sub);
        logic [TW+1:0] exp;
        int lat;
        exp = ref_op(a, b, cin, sub);
        wait_ready(tag);
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        in_cin = cin;
        in_sub = sub;
        @(negedge clk);
        in_valid = 1'b0;
        in_a = rnd_word();
        in_b = rnd_word();
        in_cin = ~cin;
        in_sub = ~sub;
        chk({tag, " busy"}, TW'({busy, in_ready}), TW'(2'b10));
        wait_valid(lat);
        chk({tag, " lat"}, TW'(lat), TW'(NW));
        chk({tag, " sum"}, out_sum, exp[TW-1:0]);
        chk({tag, " cout"}, TW'(out_cout), TW'(exp[TW]));
        chk({tag, " ovf"}, TW'(out_ovf), TW'(exp[TW+1]));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, " hs"}, TW'({out_valid, in_ready}), TW'(2'b01));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [TW-1:0] a1;
        logic [TW-1:0] ones;
        logic [TW-1:0] a5;
        logic [TW-1:0] b5;
        logic [TW-1:0] a6;
        logic [TW-1:0] b6;
        logic [TW+1:0] e5;
        logic [TW+1:0] e6;
        int            lat;

        ones = '1;
        a1 = {64'h0, 64'hFFFF_FFFF_FFFF_FFFF};
        a1[95:64] = 32'hFFFF_FFFF;

        repeat (2) @(negedge clk);
        chk("rst ctl", TW'({in_ready, out_valid, busy, out_cout, out_ovf}),
            TW'(0));
        chk("rst sum", out_sum, TW'(0));
        rst_n = 1'b1;
        #1;
        chk("rst rdy0", TW'(in_ready), TW'(0));
        @(negedge clk);
        chk("rst rdy1", TW'(in_ready), TW'(1));

        run_op("t1", a1, TW'(1), 1'b0, 1'b0);
        chk("t1 const", out_sum, {32'h1, 96'h0});
        run_op("t2", ones, TW'(0), 1'b1, 1'b0);
        chk("t2 const", out_sum, TW'(0));
        run_op("t3a", TW'(5), TW'(7), 1'b0, 1'b1);
        chk("t3a const", out_sum, ones - TW'(1));
        run_op("t3b", TW'(7), TW'(5), 1'b1, 1'b1);
        chk("t3b const", {out_sum[TW-2:0], out_cout}, {TW'(2), 1'b1});
        run_op("t4", {1'b0, {(TW-1){1'b1}}}, TW'(1), 1'b0, 1'b0);
        chk("t4 const", {out_sum[TW-2:0], out_ovf}, {(TW-1)'(0), 1'b1});

        for (int n = 0; n < 24; n++) begin
            a5 = rnd_word();
            b5 = (n % 3 == 0) ? ~a5 : rnd_word();
            run_op($sformatf("rnd%0d", n), a5, b5, 1'($urandom()),
                   1'($urandom()));
        end

        // backpressure with in_valid held high throughout
        a5 = rnd_word();
        b5 = rnd_word();
        a6 = rnd_word();
        b6 = rnd_word();
        e5 = ref_op(a5, b5, 1'b1, 1'b0);
        e6 = ref_op(a6, b6, 1'b0, 1'b1);
        wait_ready("bp");
        in_valid = 1'b1;
        in_a = a5;
        in_b = b5;
        in_cin = 1'b1;
        in_sub = 1'b0;
        @(negedge clk);
        in_a = a6;
        in_b = b6;
        in_cin = 1'b0;
        in_sub = 1'b1;
        wait_valid(lat);
        chk("bp lat", TW'(lat), TW'(NW));
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("bp ctl", TW'({out_valid, in_ready, busy}), TW'(3'b101));
            chk("bp sum", out_sum, e5[TW-1:0]);
        end
        chk("bp flags", TW'({out_ovf, out_cout}), TW'(e5[TW+1:TW]));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp rel", TW'({out_valid, in_ready}), TW'(2'b01));
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp acc2", TW'({busy, in_ready}), TW'(2'b10));
        wait_valid(lat);
        chk("bp2 lat", TW'(lat), TW'(NW));
        chk("bp2 sum", out_sum, e6[TW-1:0]);
        chk("bp2 flags", TW'({out_ovf, out_cout}), TW'(e6[TW+1:TW]));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // reset in the middle of RUN, at word 2
        wait_ready("rr");
        in_valid = 1'b1;
        in_a = a1;
        in_b = TW'(1);
        in_cin = 1'b0;
        in_sub = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rr ctl", TW'({out_valid, in_ready, busy}), TW'(0));
        chk("rr sum", out_sum, TW'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op("rr t1", a1, TW'(1), 1'b0, 1'b0);
        chk("rr const", out_sum, {32'h1, 96'h0});

        // reset while a result is waiting
        wait_ready("rd");
        in_valid = 1'b1;
        in_a = ones;
        in_b = ones;
        in_cin = 1'b1;
        in_sub = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        wait_valid(lat);
        chk("rd lat", TW'(lat), TW'(NW));
        #2;
        rst_n = 1'b0;
        #1;
        chk("rd ctl", TW'({out_valid, in_ready, busy}), TW'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op("rd t2", ones, TW'(0), 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
